// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and state encoding for the cache-line to burst-memory adaptor.
package pkg_cache;
    localparam int CACHE_LINE_W = 256;
    localparam int BURST_W      = 64;
    localparam int BURST_BEATS  = CACHE_LINE_W / BURST_W;

    typedef enum logic [1:0] {
        A_IDLE,
        A_RD_BURST,
        A_WR_BURST,
        A_DONE
    } adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one whole-line cache request into a 4-beat burst on the memory side,
// assembling read beats into a line and serialising write-back lines beat by beat.
module cacheline_adaptor
    import pkg_cache::*;
#(
    parameter int LINE_W  = CACHE_LINE_W,
    parameter int BURST_W = pkg_cache::BURST_W,
    parameter int ADDR_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [LINE_W-1:0]    line_i,
    output logic [LINE_W-1:0]    line_o,
    output logic                 resp_o,
    output logic [ADDR_W-1:0]    address_o,
    output logic                 read_o,
    output logic                 write_o,
    output logic [BURST_W-1:0]   burst_o,
    input  logic [BURST_W-1:0]   burst_i,
    input  logic                 resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    adaptor_state_t      r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_rdLine;
    logic [LINE_W-1:0]   r_wrLine;
    logic                r_read;
    logic                r_write;
    logic                r_resp;
    logic                w_lastBeat;

    assign w_lastBeat = (r_cnt == CNT_W'(BEATS - 1));

    // Write data and read data live in separate line registers so that a
    // write-back never disturbs the last line handed to the cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= A_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_rdLine <= '0;
            r_wrLine <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_resp   <= 1'b0;
        end else begin
            case (r_state)
                A_IDLE: begin
                    if (read_i || write_i) begin
                        r_addr <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        r_cnt  <= '0;
                        if (write_i) begin
                            r_wrLine <= line_i;
                            r_write  <= 1'b1;
                            r_state  <= A_WR_BURST;
                        end else begin
                            r_read  <= 1'b1;
                            r_state <= A_RD_BURST;
                        end
                    end
                end
                A_RD_BURST: begin
                    if (resp_i) begin
                        r_rdLine[int'(r_cnt)*BURST_W +: BURST_W] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_lastBeat) begin
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= A_DONE;
                        end
                    end
                end
                A_WR_BURST: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_lastBeat) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= A_DONE;
                        end
                    end
                end
                A_DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= A_IDLE;
                end
                default: r_state <= A_IDLE;
            endcase
        end
    end

    assign burst_o   = (r_state == A_WR_BURST) ? r_wrLine[int'(r_cnt)*BURST_W +: BURST_W]
                                                : '0;
    assign line_o    = r_rdLine;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor: reads, stalls, writes,
// read/write priority, asynchronous reset mid-burst and back-to-back transfers.
module tb_cacheline_adaptor;

    logic          clk;
    logic          rst_n;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic [255:0]  line_i;
    logic [255:0]  line_o;
    logic          resp_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic [63:0]   burst_o;
    logic [63:0]   burst_i;
    logic          resp_i;

    int vectorCount    = 0;
    int miscompareCount = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge, away from sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [255:0] line);
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = line;
    endtask

    task automatic beat(input logic rsp, input logic [63:0] data);
        resp_i  = rsp;
        burst_i = data;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            miscompareCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        vectorCount++;
        assert (observed === expected) else begin
            miscompareCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        resp_i  = 1'b0;
        burst_i = 64'h0;
        #12;

        $display("[TB] reset state");
        checkFlag("rst_read_o", read_o, 1'b0);
        checkFlag("rst_write_o", write_o, 1'b0);
        checkFlag("rst_resp_o", resp_o, 1'b0);
        checkOutput("rst_address_o", 256'(address_o), 256'h0);
        checkOutput("rst_line_o", line_o, 256'h0);
        checkOutput("rst_burst_o", 256'(burst_o), 256'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] read without stalls");
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 256'h0);
        tick();
        checkFlag("t1_read_o_rise", read_o, 1'b1);
        checkFlag("t1_write_o", write_o, 1'b0);
        checkOutput("t1_address_o", 256'(address_o), 256'h1234_5660);
        beat(1'b1, 64'h0000_0000_0000_0001);
        checkFlag("t1_resp_o_early", resp_o, 1'b0);
        beat(1'b1, 64'h0000_0000_0000_0002);
        beat(1'b1, 64'h0000_0000_0000_0003);
        checkFlag("t1_read_o_mid", read_o, 1'b1);
        beat(1'b1, 64'h0000_0000_0000_0004);
        checkFlag("t1_resp_o", resp_o, 1'b1);
        checkFlag("t1_read_o_done", read_o, 1'b0);
        checkOutput("t1_line_o", line_o,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        applyStimulus(1'b0, 1'b0, 32'h1234_5678, 256'h0);
        beat(1'b0, 64'h0);
        checkFlag("t1_resp_o_pulse_end", resp_o, 1'b0);
        checkOutput("t1_line_o_held", line_o,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        checkOutput("t1_address_o_held", 256'(address_o), 256'h1234_5660);

        $display("[TB] read with stalls");
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 256'h0);
        tick();
        beat(1'b1, 64'h0123_4567_89AB_CDEF);
        beat(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
        beat(1'b0, 64'hBEEF_BEEF_BEEF_BEEF);
        checkFlag("t2_resp_o_stall", resp_o, 1'b0);
        beat(1'b1, 64'hFEDC_BA98_7654_3210);
        beat(1'b1, 64'h5555_AAAA_5555_AAAA);
        beat(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
        checkFlag("t2_read_o_stall", read_o, 1'b1);
        checkFlag("t2_resp_o_before_last", resp_o, 1'b0);
        beat(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
        checkFlag("t2_resp_o", resp_o, 1'b1);
        checkFlag("t2_read_o_done", read_o, 1'b0);
        checkOutput("t2_line_o", line_o,
            256'h0F0F0F0F0F0F0F0F_5555AAAA5555AAAA_FEDCBA9876543210_0123456789ABCDEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        beat(1'b0, 64'h0);

        $display("[TB] write back");
        applyStimulus(1'b0, 1'b1, 32'h8000_001F,
            256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD);
        tick();
        checkFlag("t3_write_o_rise", write_o, 1'b1);
        checkFlag("t3_read_o", read_o, 1'b0);
        checkOutput("t3_address_o", 256'(address_o), 256'h8000_0000);
        checkOutput("t3_burst_beat0", 256'(burst_o), 256'hDDDD_DDDD_DDDD_DDDD);
        beat(1'b0, 64'h0);
        checkOutput("t3_burst_beat0_stall", 256'(burst_o), 256'hDDDD_DDDD_DDDD_DDDD);
        beat(1'b1, 64'h0);
        checkOutput("t3_burst_beat1", 256'(burst_o), 256'hCCCC_CCCC_CCCC_CCCC);
        beat(1'b1, 64'h0);
        checkOutput("t3_burst_beat2", 256'(burst_o), 256'hBBBB_BBBB_BBBB_BBBB);
        beat(1'b0, 64'h0);
        checkOutput("t3_burst_beat2_stall", 256'(burst_o), 256'hBBBB_BBBB_BBBB_BBBB);
        beat(1'b1, 64'h0);
        checkOutput("t3_burst_beat3", 256'(burst_o), 256'hAAAA_AAAA_AAAA_AAAA);
        checkFlag("t3_resp_o_early", resp_o, 1'b0);
        beat(1'b1, 64'h0);
        checkFlag("t3_resp_o", resp_o, 1'b1);
        checkFlag("t3_write_o_done", write_o, 1'b0);
        checkOutput("t3_line_o_untouched", line_o,
            256'h0F0F0F0F0F0F0F0F_5555AAAA5555AAAA_FEDCBA9876543210_0123456789ABCDEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        beat(1'b0, 64'h0);
        checkFlag("t3_resp_o_pulse_end", resp_o, 1'b0);

        $display("[TB] read and write together");
        applyStimulus(1'b1, 1'b1, 32'h0000_0100,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();
        checkFlag("t4_write_o", write_o, 1'b1);
        checkFlag("t4_read_o", read_o, 1'b0);
        checkOutput("t4_burst_beat0", 256'(burst_o), 256'h1111_1111_1111_1111);
        beat(1'b1, 64'h0);
        beat(1'b1, 64'h0);
        checkOutput("t4_burst_beat2", 256'(burst_o), 256'h3333_3333_3333_3333);
        checkFlag("t4_read_o_mid", read_o, 1'b0);
        beat(1'b1, 64'h0);
        beat(1'b1, 64'h0);
        checkFlag("t4_resp_o", resp_o, 1'b1);
        checkFlag("t4_read_o_done", read_o, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        beat(1'b0, 64'h0);

        $display("[TB] reset during read");
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 256'h0);
        tick();
        beat(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b1, 64'hEEEE_EEEE_EEEE_EEEE);
        #1;
        rst_n = 1'b0;
        #1;
        checkFlag("t5_read_o_async", read_o, 1'b0);
        checkFlag("t5_resp_o_async", resp_o, 1'b0);
        checkOutput("t5_address_o_async", 256'(address_o), 256'h0);
        checkOutput("t5_line_o_async", line_o, 256'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        resp_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkFlag("t5_no_resp_after_reset", resp_o, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, 256'h0);
        tick();
        checkOutput("t5_fresh_address_o", 256'(address_o), 256'h0000_0300);
        beat(1'b1, 64'h0000_0000_0000_00A1);
        beat(1'b1, 64'h0000_0000_0000_00B2);
        beat(1'b1, 64'h0000_0000_0000_00C3);
        beat(1'b1, 64'h0000_0000_0000_00D4);
        checkFlag("t5_fresh_resp_o", resp_o, 1'b1);
        checkOutput("t5_fresh_line_o", line_o,
            256'h00000000000000D4_00000000000000C3_00000000000000B2_00000000000000A1);

        $display("[TB] back-to-back read then write");
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        beat(1'b0, 64'h0);
        checkFlag("t6_resp_o_end", resp_o, 1'b0);
        checkFlag("t6_write_o_idle", write_o, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0420,
            256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
        tick();
        checkFlag("t6_write_o_rise", write_o, 1'b1);
        checkFlag("t6_no_spurious_resp", resp_o, 1'b0);
        checkOutput("t6_burst_beat0", 256'(burst_o), 256'h5555_5555_5555_5555);
        beat(1'b1, 64'h0);
        beat(1'b1, 64'h0);
        beat(1'b1, 64'h0);
        checkFlag("t6_resp_o_early", resp_o, 1'b0);
        beat(1'b1, 64'h0);
        checkFlag("t6_resp_o", resp_o, 1'b1);
        checkOutput("t6_line_o_kept", line_o,
            256'h00000000000000D4_00000000000000C3_00000000000000B2_00000000000000A1);
        applyStimulus(1'b0, 1'b0, 32'h0, 256'h0);
        beat(1'b0, 64'h0);
        checkFlag("t6_resp_o_pulse_end", resp_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
